// File: rtl/signal_sum.sv
// signal_sum: combines a sine and a square waveform sample into one registered
// 24-bit result. SW1 mutes channels, SW0 picks the arithmetic operation.
//
// Ports:
//   clk         rising-edge system clock
//   rst_n       asynchronous active-low reset, clears sig
//   SW0[1:0]    operation select: 00 sum, 01 diff, 10 product, 11 max
//   SW1[1:0]    mute mask: bit 0 mutes sine, bit 1 mutes square
//   sig_sine    12-bit unsigned sine sample
//   sig_square  12-bit unsigned square sample
//   sig         24-bit registered result, one per clk
module signal_sum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  SW0,
    input  logic [1:0]  SW1,
    input  logic [11:0] sig_sine,
    input  logic [11:0] sig_square,
    output logic [23:0] sig
);

    localparam int unsigned IN_W  = 12;
    localparam int unsigned OUT_W = 24;

    localparam logic [1:0] OP_SUM  = 2'b00;
    localparam logic [1:0] OP_DIFF = 2'b01;
    localparam logic [1:0] OP_PROD = 2'b10;
    localparam logic [1:0] OP_MAX  = 2'b11;

    logic [IN_W-1:0]  a;
    logic [IN_W-1:0]  b;
    logic [OUT_W-1:0] result;

    // Channel mute stage.
    always_comb begin
        a = SW1[0] ? '0 : sig_sine;
        b = SW1[1] ? '0 : sig_square;
    end

    // Operation select. All arithmetic is done at the full output width:
    // a 24-bit modular subtraction yields the sign-extended difference
    // directly, and the widest product (0xFFE001) still fits.
    always_comb begin
        result = '0;
        case (SW0)
            OP_SUM:  result = OUT_W'(a) + OUT_W'(b);
            OP_DIFF: result = OUT_W'(a) - OUT_W'(b);
            OP_PROD: result = OUT_W'(a) * OUT_W'(b);
            OP_MAX:  result = (a >= b) ? OUT_W'(a) : OUT_W'(b);
        endcase
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else begin
            sig <= result;
        end
    end

endmodule

// File: tb/tb_signal_sum.sv
// Directed self-checking bench for signal_sum.
module tb_signal_sum;

    logic        clk;
    logic        rst_n;
    logic [1:0]  SW0;
    logic [1:0]  SW1;
    logic [11:0] sig_sine;
    logic [11:0] sig_square;
    logic [23:0] sig;

    int checks;
    int errors;

    signal_sum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SW0        (SW0),
        .SW1        (SW1),
        .sig_sine   (sig_sine),
        .sig_square (sig_square),
        .sig        (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, sig=%h", sig);
        $fatal(1, "watchdog expired");
    end

    // Drive a vector after the falling edge, then let one rising edge capture it.
    task automatic apply(input logic [1:0] op, input logic [1:0] mute,
                         input logic [11:0] sine, input logic [11:0] square);
        @(negedge clk);
        SW0        = op;
        SW1        = mute;
        sig_sine   = sine;
        sig_square = square;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n      = 1'b1;
        SW0        = 2'b00;
        SW1        = 2'b00;
        sig_sine   = 12'h123;
        sig_square = 12'h456;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sig !== 24'h000000) begin
            errors++;
            $display("FAIL reset_async: sig=%h expected=%h", sig, 24'h000000);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sig !== 24'h000000) begin
            errors++;
            $display("FAIL reset_hold: sig=%h expected=%h", sig, 24'h000000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (sig !== 24'h000000) begin
            errors++;
            $display("FAIL reset_release_no_edge: sig=%h expected=%h", sig, 24'h000000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sig !== 24'h000579) begin
            errors++;
            $display("FAIL reset_first_edge: sig=%h expected=%h", sig, 24'h000579);
        end
    endtask

    task automatic test_ops;
        logic [23:0] exp_tab [4];
        exp_tab[0] = 24'h000653;
        exp_tab[1] = 24'hFFFFAD;
        exp_tab[2] = 24'h09F900;
        exp_tab[3] = 24'h000353;
        for (int i = 0; i < 4; i++) begin
            apply(2'(i), 2'b00, 12'h300, 12'h353);
            checks++;
            if (sig !== exp_tab[i]) begin
                errors++;
                $display("FAIL op_sw0_%0d: sig=%h expected=%h", i, sig, exp_tab[i]);
            end
        end
    endtask

    task automatic test_mute;
        logic [23:0] exp_tab [4];
        exp_tab[0] = 24'h000653;
        exp_tab[1] = 24'h000353;
        exp_tab[2] = 24'h000300;
        exp_tab[3] = 24'h000000;
        for (int m = 1; m < 4; m++) begin
            apply(2'b00, 2'(m), 12'h300, 12'h353);
            checks++;
            if (sig !== exp_tab[m]) begin
                errors++;
                $display("FAIL mute_sw1_%0d: sig=%h expected=%h", m, sig, exp_tab[m]);
            end
        end
        // Both channels muted: every operation yields zero.
        for (int op = 1; op < 4; op++) begin
            apply(2'(op), 2'b11, 12'hABC, 12'h123);
            checks++;
            if (sig !== 24'h000000) begin
                errors++;
                $display("FAIL mute_all_op_%0d: sig=%h expected=%h", op, sig, 24'h000000);
            end
        end
    endtask

    task automatic test_extremes;
        apply(2'b00, 2'b00, 12'hFFF, 12'hFFF);
        checks++;
        if (sig !== 24'h001FFE) begin
            errors++;
            $display("FAIL ext_sum_max: sig=%h expected=%h", sig, 24'h001FFE);
        end
        apply(2'b10, 2'b00, 12'hFFF, 12'hFFF);
        checks++;
        if (sig !== 24'hFFE001) begin
            errors++;
            $display("FAIL ext_prod_max: sig=%h expected=%h", sig, 24'hFFE001);
        end
        apply(2'b01, 2'b00, 12'hFFF, 12'hFFF);
        checks++;
        if (sig !== 24'h000000) begin
            errors++;
            $display("FAIL ext_diff_equal: sig=%h expected=%h", sig, 24'h000000);
        end
        apply(2'b01, 2'b00, 12'h000, 12'hFFF);
        checks++;
        if (sig !== 24'hFFF001) begin
            errors++;
            $display("FAIL ext_diff_min: sig=%h expected=%h", sig, 24'hFFF001);
        end
        apply(2'b01, 2'b00, 12'hFFF, 12'h000);
        checks++;
        if (sig !== 24'h000FFF) begin
            errors++;
            $display("FAIL ext_diff_max: sig=%h expected=%h", sig, 24'h000FFF);
        end
        // MAX picks the larger channel in either position.
        apply(2'b11, 2'b00, 12'h801, 12'h7FF);
        checks++;
        if (sig !== 24'h000801) begin
            errors++;
            $display("FAIL ext_max_sine: sig=%h expected=%h", sig, 24'h000801);
        end
    endtask

    task automatic test_latency;
        apply(2'b00, 2'b00, 12'h300, 12'h353);
        @(negedge clk);
        SW0 = 2'b01;
        #2;
        checks++;
        if (sig !== 24'h000653) begin
            errors++;
            $display("FAIL latency_hold: sig=%h expected=%h", sig, 24'h000653);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sig !== 24'hFFFFAD) begin
            errors++;
            $display("FAIL latency_update: sig=%h expected=%h", sig, 24'hFFFFAD);
        end
    endtask

    task automatic test_back_to_back;
        apply(2'b10, 2'b00, 12'h010, 12'h020);
        checks++;
        if (sig !== 24'h000200) begin
            errors++;
            $display("FAIL b2b_prod: sig=%h expected=%h", sig, 24'h000200);
        end
        apply(2'b11, 2'b00, 12'h010, 12'h020);
        checks++;
        if (sig !== 24'h000020) begin
            errors++;
            $display("FAIL b2b_max: sig=%h expected=%h", sig, 24'h000020);
        end
    endtask

    task automatic test_reset_midop;
        apply(2'b00, 2'b00, 12'h111, 12'h222);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sig !== 24'h000000) begin
            errors++;
            $display("FAIL midop_reset_async: sig=%h expected=%h", sig, 24'h000000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sig !== 24'h000333) begin
            errors++;
            $display("FAIL midop_resume: sig=%h expected=%h", sig, 24'h000333);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ops();
        test_mute();
        test_extremes();
        test_latency();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
